// File: rtl/scaler_pkg.sv
// Shared widths and FSM state encoding for the scaler read path.
package scaler_pkg;

    localparam int SCALER_HI_W = 14;
    localparam int SCALER_LO_W = 14;
    localparam int SNAP_W      = SCALER_HI_W + SCALER_LO_W;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_RD_HI1 = 3'd1;
    localparam logic [2:0] ST_RD_LO  = 3'd2;
    localparam logic [2:0] ST_RD_HI2 = 3'd3;
    localparam logic [2:0] ST_CHECK  = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

endpackage

// File: rtl/scaler_read_sequencer_if.sv
// Client handshake plus scaler read bus, bundled for the sequencer.
//
// Handshake: a client raises req[i] and holds it until it sees done with
// gnt[i] set. gnt is one-hot and stays asserted from the cycle after the
// request is sampled through the done cycle. done is a single-cycle pulse;
// snap and err are valid in that cycle and hold until the next done.
// RCHAT_/RCHBT_ are active-low strobes; chat/chbt must be stable while the
// matching strobe is low.
interface scaler_read_sequencer_if
    import scaler_pkg::*;
#(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        gnt;
    logic                   done;
    logic [SNAP_W-1:0]      snap;
    logic                   err;
    logic                   RCHAT_;
    logic                   RCHBT_;
    logic [SCALER_HI_W-1:0] chat;
    logic [SCALER_LO_W-1:0] chbt;

    modport master (
        input  req, chat, chbt,
        output gnt, done, snap, err, RCHAT_, RCHBT_
    );

    modport slave (
        output req, chat, chbt,
        input  gnt, done, snap, err, RCHAT_, RCHBT_
    );
endinterface

// File: rtl/scaler_read_sequencer_rr_arbiter.sv
// Rotating-priority arbiter: grants the first requester at or after the
// pointer and moves the pointer past the winner when told to advance.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] grant,
    output logic            any
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTR_W-1:0] pointer;
    logic [PTR_W-1:0] gidx;
    logic [PTR_W-1:0] k;
    logic [PTR_W:0]   sum;

    // Scan from the pointer upward, wrapping, and take the first request.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        gidx  = '0;
        sum   = '0;
        k     = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, pointer} + (PTR_W+1)'(i);
            if (sum >= (PTR_W+1)'(NREQ)) begin
                sum = sum - (PTR_W+1)'(NREQ);
            end
            k = sum[PTR_W-1:0];
            if (!any && req[k]) begin
                any      = 1'b1;
                grant[k] = 1'b1;
                gidx     = k;
            end
        end
    end

    // Pointer moves to one past the winner whenever a grant is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pointer <= '0;
        end else if (advance && any) begin
            if (gidx == PTR_W'(NREQ-1)) begin
                pointer <= '0;
            end else begin
                pointer <= gidx + PTR_W'(1);
            end
        end
    end
endmodule

// File: rtl/scaler_read_sequencer.sv
// Arbitrates clients for a coherent 28-bit scaler snapshot. Reads the high
// channel, the low channel, then the high channel again; a high-word mismatch
// means a carry rippled across mid-read, so the whole sequence is retried.
module scaler_read_sequencer
    import scaler_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int STROBE_CYC = 3,
    parameter int MAX_RETRY  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    scaler_read_sequencer_if.master bus,
    output state_t                state_dbg
);
    localparam int CNT_W = 4;
    localparam int RTY_W = 3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STROBE_CYC);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [RTY_W-1:0]       retry;
    logic [SCALER_HI_W-1:0] hi1;
    logic [SCALER_HI_W-1:0] hi2;
    logic [SCALER_LO_W-1:0] lo;
    logic [NREQ-1:0]        gnt_q;
    logic [SNAP_W-1:0]      snap_q;
    logic                   err_q;
    logic [NREQ-1:0]        arb_grant;
    logic                   arb_any;
    logic                   strobe_phase;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.req),
        .advance (state == ST_IDLE),
        .grant   (arb_grant),
        .any     (arb_any)
    );

    // Count 0 of every read state is the both-high gap; counts 1..STROBE_CYC
    // hold the strobe low, so the two strobes can never overlap.
    assign strobe_phase = (cnt != '0);
    assign bus.RCHAT_   = !(((state == ST_RD_HI1) || (state == ST_RD_HI2)) && strobe_phase);
    assign bus.RCHBT_   = !((state == ST_RD_LO) && strobe_phase);
    assign bus.done     = (state == ST_DONE);
    assign bus.gnt      = gnt_q;
    assign bus.snap     = snap_q;
    assign bus.err      = err_q;
    assign state_dbg    = state;

    // Sequencer FSM: grant, three strobed reads, compare, complete.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            retry  <= '0;
            hi1    <= '0;
            hi2    <= '0;
            lo     <= '0;
            gnt_q  <= '0;
            snap_q <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        gnt_q <= arb_grant;
                        cnt   <= '0;
                        state <= ST_RD_HI1;
                    end
                end
                ST_RD_HI1: begin
                    if (cnt == CNT_LAST) begin
                        hi1   <= bus.chat;
                        cnt   <= '0;
                        state <= ST_RD_LO;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_RD_LO: begin
                    if (cnt == CNT_LAST) begin
                        lo    <= bus.chbt;
                        cnt   <= '0;
                        state <= ST_RD_HI2;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_RD_HI2: begin
                    if (cnt == CNT_LAST) begin
                        hi2   <= bus.chat;
                        cnt   <= '0;
                        state <= ST_CHECK;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (hi1 == hi2) begin
                        snap_q <= {hi2, lo};
                        err_q  <= 1'b0;
                        state  <= ST_DONE;
                    end else if (retry < RTY_MAX) begin
                        retry <= retry + RTY_W'(1);
                        state <= ST_RD_HI1;
                    end else begin
                        snap_q <= {hi2, lo};
                        err_q  <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    gnt_q <= '0;
                    retry <= '0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_scaler_read_sequencer.sv
// Bench for scaler_read_sequencer: scripted scaler responder, rotating
// priority reference, per-cycle strobe protocol monitor.
module tb_scaler_read_sequencer;
    import scaler_pkg::*;

    localparam int NREQ = 4;
    localparam int S    = 3;
    localparam int MR   = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    scaler_read_sequencer_if #(.NREQ(NREQ)) bus ();
    state_t state_dbg;

    scaler_read_sequencer #(.NREQ(NREQ), .STROBE_CYC(S), .MAX_RETRY(MR)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Values the scaler will present on successive A / B reads.
    logic [13:0] a_plan[$];
    logic [13:0] b_plan[$];
    int plan_id = 0;
    int ptr_m   = 0;

    // ---------------- scaler responder ----------------
    int   a_idx = 0;
    int   b_idx = 0;
    int   seen_id = 0;
    logic last_a = 1'b1;
    logic last_b = 1'b1;

    initial begin
        bus.chat = '0;
        bus.chbt = '0;
        forever begin
            @(posedge clk);
            #1;
            if (seen_id != plan_id) begin
                seen_id = plan_id;
                a_idx   = 0;
                b_idx   = 0;
            end
            if (!bus.RCHAT_ && last_a) begin
                bus.chat = (a_idx < a_plan.size()) ? a_plan[a_idx] : 14'($urandom);
                a_idx++;
            end
            if (!bus.RCHBT_ && last_b) begin
                bus.chbt = (b_idx < b_plan.size()) ? b_plan[b_idx] : 14'($urandom);
                b_idx++;
            end
            last_a = bus.RCHAT_;
            last_b = bus.RCHBT_;
        end
    end

    // ---------------- strobe protocol monitor ----------------
    int   run_a = 0;
    int   run_b = 0;
    logic prev_both_high = 1'b1;

    always @(negedge clk) begin
        if (rst) begin
            run_a          = 0;
            run_b          = 0;
            prev_both_high = 1'b1;
        end else begin
            chk("strobe_overlap", 32'(!bus.RCHAT_ && !bus.RCHBT_), 32'd0);
            chk("gnt_onehot", 32'($countones(bus.gnt) <= 1), 32'd1);
            if (!bus.RCHAT_) begin
                if (run_a == 0) chk("gap_before_rchat", 32'(prev_both_high), 32'd1);
                run_a++;
            end else if (run_a != 0) begin
                chk("rchat_width", run_a, S);
                run_a = 0;
            end
            if (!bus.RCHBT_) begin
                if (run_b == 0) chk("gap_before_rchbt", 32'(prev_both_high), 32'd1);
                run_b++;
            end else if (run_b != 0) begin
                chk("rchbt_width", run_b, S);
                run_b = 0;
            end
            prev_both_high = bus.RCHAT_ && bus.RCHBT_;
        end
    end

    // ---------------- reference model ----------------
    // Pass p reads A twice and B once; the first pass whose two A reads agree
    // wins; after MR retries the last pass is reported with err.
    task automatic model(output logic [27:0] s, output logic e, output int passes);
        s      = '0;
        e      = 1'b1;
        passes = 0;
        for (int p = 0; p <= MR; p++) begin
            passes = p + 1;
            s = 28'(a_plan[2*p+1]) * 28'd16384 + 28'(b_plan[p]);
            if (a_plan[2*p] == a_plan[2*p+1]) begin
                e = 1'b0;
                break;
            end
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] mask, input int ptr);
        for (int i = 0; i < NREQ; i++) begin
            if (mask[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
        end
        return -1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic gen_plan();
        logic [13:0] h;
        a_plan.delete();
        b_plan.delete();
        for (int p = 0; p <= MR; p++) begin
            h = 14'($urandom);
            a_plan.push_back(h);
            if ($urandom_range(0, 2) == 0) a_plan.push_back(h ^ 14'($urandom_range(1, 16383)));
            else                           a_plan.push_back(h);
            b_plan.push_back(14'($urandom));
        end
    endtask

    task automatic wait_done(output int at, output bit ok);
        ok = 1'b0;
        at = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.done) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
        if (!ok) chk("done_timeout", 32'd0, 32'd1);
    endtask

    // Called at a negedge with the DUT idle; that cycle is the req-sample cycle.
    task automatic run_txn(input logic [NREQ-1:0] mask, input bit fresh, input bit drop,
                           input bit keep, output logic [NREQ-1:0] seen_gnt);
        int          exp_idx, t0, at, passes;
        bit          ok;
        logic [27:0] es;
        logic        ee;
        if (fresh) gen_plan();
        plan_id++;
        model(es, ee, passes);
        exp_idx = pick(mask, ptr_m);
        ptr_m   = (exp_idx + 1) % NREQ;
        bus.req = mask;
        t0      = cyc;
        if (drop) begin
            repeat (3) @(negedge clk);
            bus.req = '0;
        end
        wait_done(at, ok);
        seen_gnt = bus.gnt;
        if (ok) begin
            chk("txn_gnt", 32'(bus.gnt), 32'(1) << exp_idx);
            chk("txn_snap", 32'(bus.snap), 32'(es));
            chk("txn_err", 32'(bus.err), 32'(ee));
            chk("txn_a_reads", a_idx, 2 * passes);
            chk("txn_b_reads", b_idx, passes);
            chk("txn_latency", at - t0 + 1, 2 + passes * (3 * (S + 1) + 1));
        end
        if (!keep) bus.req = '0;
        @(negedge clk);
        chk("idle_gap_gnt", 32'(bus.gnt), 32'd0);
        chk("idle_gap_done", 32'(bus.done), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    logic [NREQ-1:0] g;
    logic [NREQ-1:0] order_exp [5];
    bit              hit_lo;

    initial begin
        order_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        bus.req = '0;
        repeat (3) @(negedge clk);

        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_snap", 32'(bus.snap), 32'd0);
        chk("rst_rchat", 32'(bus.RCHAT_), 32'd1);
        chk("rst_rchbt", 32'(bus.RCHBT_), 32'd1);
        chk("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        rst   = 1'b0;
        ptr_m = 0;
        @(negedge clk);

        // Single request with fixed bus values.
        a_plan.delete(); b_plan.delete();
        for (int i = 0; i < 2 * (MR + 1); i++) a_plan.push_back(14'h0123);
        for (int i = 0; i < MR + 1; i++)       b_plan.push_back(14'h2AAA);
        run_txn(4'b0001, 1'b0, 1'b0, 1'b0, g);
        chk("single_gnt", 32'(g), 32'h1);
        chk("single_snap", 32'(bus.snap), 32'h048EAAA);
        chk("single_err", 32'(bus.err), 32'd0);

        // Carry tear: high word changes between the two high reads of pass 1.
        a_plan.delete(); b_plan.delete();
        a_plan = '{14'h0005, 14'h0006, 14'h0006, 14'h0006, 14'h0006, 14'h0006, 14'h0006, 14'h0006};
        b_plan = '{14'h1111, 14'h2222, 14'h3333, 14'h0444};
        run_txn(4'b0010, 1'b0, 1'b0, 1'b0, g);
        chk("tear_snap", 32'(bus.snap), (32'h6 << 14) | 32'h2222);
        chk("tear_err", 32'(bus.err), 32'd0);

        // Persistent mismatch: high word toggles on every read.
        a_plan.delete(); b_plan.delete();
        for (int i = 0; i < 2 * (MR + 1); i++) a_plan.push_back((i % 2) ? 14'h0006 : 14'h0005);
        for (int i = 0; i < MR + 1; i++)       b_plan.push_back(14'($urandom));
        run_txn(4'b0100, 1'b0, 1'b0, 1'b0, g);
        chk("persist_err", 32'(bus.err), 32'd1);
        chk("persist_snap", 32'(bus.snap), (32'h6 << 14) | 32'(b_plan[MR]));

        // Clean transaction after an error clears err.
        a_plan.delete(); b_plan.delete();
        for (int i = 0; i < 2 * (MR + 1); i++) a_plan.push_back(14'h3FFF);
        for (int i = 0; i < MR + 1; i++)       b_plan.push_back(14'h0001);
        run_txn(4'b1000, 1'b0, 1'b0, 1'b0, g);
        chk("err_cleared", 32'(bus.err), 32'd0);

        // Contention from pointer 0: reset first so the rotation starts fresh.
        rst = 1'b1;
        plan_id++;
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        ptr_m = 0;
        for (int i = 0; i < 5; i++) begin
            run_txn(4'b1111, 1'b1, 1'b0, (i < 4), g);
            chk($sformatf("contention_%0d", i), 32'(g), 32'(order_exp[i]));
        end

        // Requester drops req mid-transaction; completion still happens.
        run_txn(4'b0010, 1'b1, 1'b1, 1'b0, g);

        // Leave the pointer at 3, then reset during the low-word read.
        run_txn(4'b0100, 1'b1, 1'b0, 1'b0, g);
        gen_plan();
        plan_id++;
        bus.req = 4'b0100;
        hit_lo  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus.RCHBT_) begin
                hit_lo = 1'b1;
                break;
            end
        end
        chk("reach_rd_lo", 32'(hit_lo), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_rchbt", 32'(bus.RCHBT_), 32'd1);
        chk("midrst_rchat", 32'(bus.RCHAT_), 32'd1);
        chk("midrst_gnt", 32'(bus.gnt), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        ptr_m   = 0;
        bus.req = 4'b1010;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_txn(4'b1010, 1'b1, 1'b0, 1'b0, g);
        chk("midrst_regrant", 32'(g), 32'h2);

        // Randomized requests against the rotating-priority model.
        for (int i = 0; i < 20; i++) begin
            run_txn(4'($urandom_range(1, 15)), 1'b1, ($urandom_range(0, 3) == 0), 1'b0, g);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
